led_fade_driver: RTL and testbench
==================================

LED_FADE_DRIVER -- requirements
Module: led_fade_driver

Interface
REQ-001 Parameter FADE_DIV, default 27000: clocks per brightness step (minimum 2).
REQ-002 Parameter STEP, default 17: brightness increment/decrement per step (1..255).
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means a pad driven low lights its LED.
REQ-004 sys_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 sys_rst  input  1  reset; asynchronous, active-high.
REQ-006 enable  input  1  1 runs the counters and outputs; 0 freezes state and blanks the LEDs.
REQ-007 pattern_in  input  6  requested on/off pattern from the sequencer; bit i is LED i, 1 means on.
REQ-008 pattern_valid  input  1  one-cycle strobe; loads pattern_in as the new target.
REQ-009 led  output  6  registered PWM pad drive, polarity set by ACTIVE_LOW.
REQ-010 busy  output  1  registered; 1 while any LED brightness differs from its target level.

Function
REQ-011 The block shall keep, per LED, an 8-bit brightness bright[i] and a target bit tgt[i]; target level = 255 if tgt[i]=1, else 0.
REQ-012 When pattern_valid=1 and enable=1, tgt shall take pattern_in at that clock edge; pattern_valid while enable=0 shall be ignored.
REQ-013 An 8-bit free-running pwm_cnt (0..255, wraps to 0) shall advance by one each enabled cycle.
REQ-014 A fade divider shall count 0..FADE_DIV-1 on enabled cycles and wrap; fade_tick=1 on the cycle it equals FADE_DIV-1.
REQ-015 On fade_tick, each bright[i] below its target level shall rise by STEP, saturating at 255; each above shall fall by STEP, saturating at 0; equal stays.
REQ-016 Fade arithmetic shall use 9 bits internally; results outside 0..255 shall clamp, with no wrap-around.
REQ-017 If pattern_valid coincides with fade_tick, that tick shall use the old tgt; the new target applies from the next tick.
REQ-018 A retarget mid-fade shall reverse direction from the current bright[i], with no jump.
REQ-019 LED i lit condition: bright[i]=255, or pwm_cnt < bright[i]; bright[i]=0 is never lit.
REQ-020 led[i] shall register the lit condition one cycle after the pwm_cnt value used, inverted when ACTIVE_LOW=1.
REQ-021 When enable=0, all counters, bright and tgt shall hold, and led shall be driven to the off level on the next edge.
REQ-022 busy shall be registered as the OR over i of (bright[i] != target level), updated every cycle regardless of enable.
REQ-023 Latency, pattern_valid to first brightness change: at most FADE_DIV+1 clocks.
REQ-024 Latency, full fade 0 to 255 with STEP=17: exactly 15 fade ticks.

Reset
REQ-025 Reset shall clear, asynchronously, pwm_cnt, the fade divider, all bright[i] and all tgt[i] to 0.
REQ-026 During reset, led = 6'b111111 if ACTIVE_LOW=1, else 6'b000000; busy = 0.
REQ-027 Reset asserted mid-fade shall abandon the fade; after release, all LEDs are dark until a new pattern_valid.
REQ-028 The first enabled edge after reset release shall see pwm_cnt=0 and divider=0.

Verification
REQ-029 Setup FADE_DIV=4, STEP=17, ACTIVE_LOW=1: pattern_in=6'b000001 strobed -> bright[0] steps 17,34,...,255 on every 4th cycle; busy drops the cycle after 255 is reached.
REQ-030 Steady state, bright[0]=255 -> led[0]=0 every cycle; led[5:1]=1 every cycle.
REQ-031 From bright[0]=136, strobe 6'b000000 -> bright[0] steps 119,102,... to 0 and never underflows.
REQ-032 pattern_valid on a fade_tick cycle -> that tick moves toward the old target; the following tick moves toward the new one.
REQ-033 enable=0 for 50 cycles mid-fade -> led=6'b111111 and bright frozen; resume continues from the same values.
REQ-034 sys_rst pulsed mid-fade -> immediate led=6'b111111 and busy=0, with all state at 0 after release.

Source files
------------

// File: rtl/led_fade_driver_if.sv
// Sequencer-side bundle for led_fade_driver: pattern requests in, pad drive
// and fade status out. The sequencer owns the master view, the driver the
// slave view.
interface led_fade_driver_if;
   logic       enable;
   logic [5:0] pattern_in;
   logic       pattern_valid;
   logic [5:0] led;
   logic       busy;

   modport master (
      output enable,
      output pattern_in,
      output pattern_valid,
      input  led,
      input  busy
   );

   modport slave (
      input  enable,
      input  pattern_in,
      input  pattern_valid,
      output led,
      output busy
   );
endinterface

// File: rtl/led_fade_driver.sv
// Six-channel LED fader. Each LED has an 8-bit brightness that ramps toward
// a full-on or full-off target by STEP every FADE_DIV enabled clocks. The
// brightness is rendered as PWM against a free-running 8-bit counter, and the
// pad polarity is set by ACTIVE_LOW.
module led_fade_driver #(
   parameter int FADE_DIV   = 27000,
   parameter int STEP       = 17,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic               sys_clk,
   input logic               sys_rst,
   led_fade_driver_if.slave  bus
);

   localparam int                DIV_W     = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FADE_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [7:0]        STEP_U8   = 8'(STEP);
   localparam logic [5:0]        POL_MASK  = ACTIVE_LOW ? 6'b111111 : 6'b000000;
   localparam logic [5:0]        OFF_LEVEL = ACTIVE_LOW ? 6'b111111 : 6'b000000;

   logic [7:0]       pwm_cnt_r;
   logic [DIV_W-1:0] div_r;
   logic [5:0]       tgt_r;
   logic [7:0]       bright_r [6];
   logic [5:0]       led_r;
   logic             busy_r;

   logic             fade_tick_s;
   logic [5:0]       lit_s;
   logic             busy_next_s;

   // One fade step toward the target rail, computed 9 bits wide so that an
   // overshoot in either direction clamps to the rail instead of wrapping.
   function automatic logic [7:0] fade_step(input logic [7:0] cur, input logic up);
      logic [8:0] wide;
      logic [7:0] result;
      if (up) begin
         wide = {1'b0, cur} + {1'b0, STEP_U8};
         if (wide > 9'd255) begin
            result = 8'd255;
         end else begin
            result = wide[7:0];
         end
      end else begin
         wide = {1'b0, cur} - {1'b0, STEP_U8};
         if (wide[8]) begin
            result = 8'd0;
         end else begin
            result = wide[7:0];
         end
      end
      return result;
   endfunction

   // PWM compare: full brightness is solid on, zero is never lit.
   function automatic logic is_lit(input logic [7:0] bright, input logic [7:0] cnt);
      return (bright == 8'd255) || (cnt < bright);
   endfunction

   // Fade tick fires on the last divider count of an enabled cycle.
   always_comb begin
      fade_tick_s = 1'b0;
      if (bus.enable && (div_r == DIV_LAST)) begin
         fade_tick_s = 1'b1;
      end else begin
         fade_tick_s = 1'b0;
      end
   end

   // Per-LED lit condition and the "still fading" summary from current state.
   always_comb begin
      lit_s       = 6'b000000;
      busy_next_s = 1'b0;
      for (int i = 0; i < 6; i++) begin
         lit_s[i] = is_lit(bright_r[i], pwm_cnt_r);
         if (bright_r[i] != {8{tgt_r[i]}}) begin
            busy_next_s = 1'b1;
         end else begin
            busy_next_s = busy_next_s;
         end
      end
   end

   // Counters, targets and brightness; everything freezes while disabled.
   // Brightness updates read the pre-edge tgt_r, so a strobe landing on a
   // tick only steers the following tick.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pwm_cnt_r <= 8'd0;
         div_r     <= DIV_ZERO;
         tgt_r     <= 6'b000000;
         for (int i = 0; i < 6; i++) begin
            bright_r[i] <= 8'd0;
         end
      end else if (bus.enable) begin
         pwm_cnt_r <= pwm_cnt_r + 8'd1;
         if (fade_tick_s) begin
            div_r <= DIV_ZERO;
         end else begin
            div_r <= div_r + DIV_ONE;
         end
         if (bus.pattern_valid) begin
            tgt_r <= bus.pattern_in;
         end else begin
            tgt_r <= tgt_r;
         end
         for (int i = 0; i < 6; i++) begin
            if (fade_tick_s) begin
               bright_r[i] <= fade_step(bright_r[i], tgt_r[i]);
            end else begin
               bright_r[i] <= bright_r[i];
            end
         end
      end else begin
         pwm_cnt_r <= pwm_cnt_r;
         div_r     <= div_r;
         tgt_r     <= tgt_r;
      end
   end

   // Registered pad drive and busy flag; pads go dark when disabled.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         led_r  <= OFF_LEVEL;
         busy_r <= 1'b0;
      end else begin
         if (bus.enable) begin
            led_r <= lit_s ^ POL_MASK;
         end else begin
            led_r <= OFF_LEVEL;
         end
         busy_r <= busy_next_s;
      end
   end

   assign bus.led  = led_r;
   assign bus.busy = busy_r;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver with FADE_DIV=4, STEP=17 and
// active-low pads. A cycle-level reference model built from the fade rules
// (integer brightness, min/max clamping) predicts led, busy and the per-LED
// brightness after every clock.
module tb_led_fade_driver;

   localparam int FADE_DIV = 4;
   localparam int STEP     = 17;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;

   led_fade_driver_if bus_if ();

   led_fade_driver #(
      .FADE_DIV   (FADE_DIV),
      .STEP       (STEP),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus_if)
   );

   always #5 sys_clk = ~sys_clk;

   int         n_cmp = 0;
   int         n_bad = 0;

   int         m_bright [6];
   logic [5:0] m_tgt;
   int         m_pwm;
   int         m_div;
   logic [5:0] exp_led;
   logic       exp_busy;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) begin
         m_bright[i] = 0;
      end
      m_tgt    = 6'b000000;
      m_pwm    = 0;
      m_div    = 0;
      exp_led  = 6'b111111;
      exp_busy = 1'b0;
   endtask

   // Advance the reference by one clock edge using the inputs now on the bus.
   task automatic model_step();
      int goal;
      exp_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         goal = m_tgt[i] ? 255 : 0;
         if (m_bright[i] != goal) exp_busy = 1'b1;
      end
      if (bus_if.enable) begin
         for (int i = 0; i < 6; i++) begin
            exp_led[i] = !((m_bright[i] == 255) || (m_pwm < m_bright[i]));
         end
         if (m_div == FADE_DIV - 1) begin
            for (int i = 0; i < 6; i++) begin
               goal = m_tgt[i] ? 255 : 0;
               if (m_bright[i] < goal) begin
                  m_bright[i] = (m_bright[i] + STEP > 255) ? 255 : m_bright[i] + STEP;
               end else if (m_bright[i] > goal) begin
                  m_bright[i] = (m_bright[i] - STEP < 0) ? 0 : m_bright[i] - STEP;
               end
            end
         end
         if (bus_if.pattern_valid) m_tgt = bus_if.pattern_in;
         m_pwm = (m_pwm + 1) % 256;
         m_div = (m_div + 1) % FADE_DIV;
      end else begin
         exp_led = 6'b111111;
      end
   endtask

   task automatic compare_all(input string phase);
      logic [47:0] ob;
      logic [47:0] ex;
      for (int i = 0; i < 6; i++) begin
         ob[i*8 +: 8] = dut.bright_r[i];
         ex[i*8 +: 8] = 8'(m_bright[i]);
      end
      check_eq({phase, ".led"},    64'(bus_if.led),  64'(exp_led));
      check_eq({phase, ".busy"},   64'(bus_if.busy), 64'(exp_busy));
      check_eq({phase, ".bright"}, 64'(ob),          64'(ex));
   endtask

   task automatic run_cycle(input string phase);
      @(posedge sys_clk);
      if (sys_rst) model_reset();
      else         model_step();
      #1;
      compare_all(phase);
   endtask

   task automatic strobe(input string phase, input logic [5:0] pat);
      bus_if.pattern_in    = pat;
      bus_if.pattern_valid = 1'b1;
      run_cycle(phase);
      bus_if.pattern_valid = 1'b0;
   endtask

   initial begin
      bus_if.enable        = 1'b0;
      bus_if.pattern_in    = 6'b000000;
      bus_if.pattern_valid = 1'b0;
      model_reset();

      // Reset state, visible asynchronously before any clock edge.
      #2 sys_rst = 1'b1;
      #1 compare_all("reset");
      run_cycle("reset");
      run_cycle("reset");
      @(negedge sys_clk);
      sys_rst = 1'b0;

      // Full fade up on LED0 through to the busy drop and steady state.
      bus_if.enable = 1'b1;
      strobe("fade_up", 6'b000001);
      for (int k = 0; k < 80; k++) run_cycle("fade_up");
      check_eq("fade_up.done", 64'(dut.bright_r[0]), 64'd255);

      // Fade back down partway, then reverse mid-fade.
      strobe("fade_down", 6'b000000);
      for (int k = 0; k < 30; k++) run_cycle("fade_down");
      strobe("reverse", 6'b101011);
      for (int k = 0; k < 20; k++) run_cycle("reverse");

      // Strobe exactly on a fade tick cycle.
      for (int k = 0; k < 8 && m_div != FADE_DIV - 1; k++) run_cycle("align");
      strobe("tick_strobe", ~m_tgt);
      for (int k = 0; k < 12; k++) run_cycle("tick_strobe");

      // Disable for 50 cycles mid-fade, then resume.
      bus_if.enable = 1'b0;
      bus_if.pattern_in    = 6'b010101;
      bus_if.pattern_valid = 1'b1;
      for (int k = 0; k < 50; k++) run_cycle("disabled");
      bus_if.pattern_valid = 1'b0;
      bus_if.enable = 1'b1;
      for (int k = 0; k < 30; k++) run_cycle("resume");

      // Reset pulse mid-fade; LEDs stay dark afterwards until a new strobe.
      strobe("pre_reset", 6'b111111);
      for (int k = 0; k < 25; k++) run_cycle("pre_reset");
      #2 sys_rst = 1'b1;
      #1;
      model_reset();
      compare_all("mid_reset");
      run_cycle("mid_reset");
      @(negedge sys_clk);
      sys_rst = 1'b0;
      for (int k = 0; k < 20; k++) run_cycle("post_reset");

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         bus_if.enable        = ($urandom_range(0, 9) != 0);
         bus_if.pattern_valid = ($urandom_range(0, 39) == 0);
         bus_if.pattern_in    = 6'($urandom_range(0, 63));
         run_cycle("random");
      end
      bus_if.pattern_valid = 1'b0;
      bus_if.enable        = 1'b1;
      for (int k = 0; k < 80; k++) run_cycle("settle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
